// File: rtl/vend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_pkg : shared types and constants for the vending customer agent |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package vend_pkg;

   localparam int COST_W = 3;
   localparam int ITEM_W = 4;

   localparam logic [2:0] RES_OK       = 3'd0;
   localparam logic [2:0] RES_INVALID  = 3'd1;
   localparam logic [2:0] RES_NO_FUNDS = 3'd2;
   localparam logic [2:0] RES_FAILED   = 3'd3;
   localparam logic [2:0] RES_TIMEOUT  = 3'd4;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_INSERT    = 4'd1,
      ST_KEY1      = 4'd2,
      ST_GAP       = 4'd3,
      ST_KEY2      = 4'd4,
      ST_WAIT_COST = 4'd5,
      ST_PAY       = 4'd6,
      ST_WAIT_VEND = 4'd7,
      ST_DOOR      = 4'd8,
      ST_WAIT_FAIL = 4'd9,
      ST_EJECT     = 4'd10,
      ST_REPORT    = 4'd11
   } state_t;

   // States that share the response timeout counter
   function automatic logic is_wait(input state_t s);
      return (s == ST_WAIT_COST) || (s == ST_WAIT_VEND) || (s == ST_WAIT_FAIL);
   endfunction

endpackage
`default_nettype wire

// File: rtl/vend_customer_agent_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_customer_agent_if : request and machine-side signal bundle      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface vend_customer_agent_if #(
   parameter int BAL_W = 8
);
   import vend_pkg::*;

   logic                REQ_VALID;
   logic                REQ_READY;
   logic [7:0]          REQ_ITEM;
   logic                LOAD_BAL;
   logic [BAL_W-1:0]    REQ_BALANCE;
   logic                CARD_IN;
   logic                KEY_PRESS;
   logic [ITEM_W-1:0]   ITEM_CODE;
   logic                VALID_TRAN;
   logic                DOOR_OPEN;
   logic                VEND;
   logic                INVALID_SEL;
   logic [COST_W-1:0]   COST;
   logic                FAILED_TRAN;
   logic                DONE;
   logic [2:0]          RESULT;
   logic [BAL_W-1:0]    BALANCE;

   modport master (
      input  REQ_VALID, REQ_ITEM, LOAD_BAL, REQ_BALANCE,
      input  VEND, INVALID_SEL, COST, FAILED_TRAN,
      output REQ_READY, CARD_IN, KEY_PRESS, ITEM_CODE, VALID_TRAN, DOOR_OPEN,
      output DONE, RESULT, BALANCE
   );

   modport slave (
      output REQ_VALID, REQ_ITEM, LOAD_BAL, REQ_BALANCE,
      output VEND, INVALID_SEL, COST, FAILED_TRAN,
      input  REQ_READY, CARD_IN, KEY_PRESS, ITEM_CODE, VALID_TRAN, DOOR_OPEN,
      input  DONE, RESULT, BALANCE
   );

endinterface
`default_nettype wire

// File: rtl/vend_timeout_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_timeout_ctr : response timeout counter shared by the wait states|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module vend_timeout_ctr #(
   parameter int LIMIT = 8
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic i_clear,
   input  wire logic i_enable,
   output logic      o_tc
);

   localparam int              CW     = $clog2(LIMIT + 1);
   localparam logic [CW-1:0]   c_last = CW'(LIMIT - 1);

   logic [CW-1:0] r_cnt;

   // Terminal count flags the LIMIT-th waiting cycle, so the exit edge lands
   // exactly LIMIT cycles after entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (i_clear)
         r_cnt <= '0;
      else if (i_enable && (r_cnt != c_last))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_tc = i_enable && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/vend_customer_agent.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_customer_agent : customer-side driver for the vending machine   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module vend_customer_agent #(
   parameter int BAL_W        = 8,
   parameter int KEY_GAP      = 1,
   parameter int RESP_TIMEOUT = 8,
   parameter int DOOR_CYCLES  = 1
) (
   input  wire logic            CLK,
   input  wire logic            RESET,
   vend_customer_agent_if.master bus
);
   import vend_pkg::*;

   localparam int                HOLD_MAX    = (KEY_GAP > DOOR_CYCLES) ? KEY_GAP : DOOR_CYCLES;
   localparam int                HOLD_W      = $clog2(HOLD_MAX + 1);
   localparam logic [HOLD_W-1:0] c_gap_last  = HOLD_W'(KEY_GAP - 1);
   localparam logic [HOLD_W-1:0] c_door_last = HOLD_W'(DOOR_CYCLES - 1);

   state_t              r_state, w_state_next;
   logic [2:0]          r_result, w_result_next;
   logic [7:0]          r_item;
   logic [COST_W-1:0]   r_cost;
   logic [BAL_W-1:0]    r_balance;
   logic [HOLD_W-1:0]   r_hold_cnt;
   logic                r_req_ready, r_card_in, r_key_press, r_valid_tran, r_door_open, r_done;
   logic [ITEM_W-1:0]   r_item_code;
   logic                w_req_ready, w_card_in, w_key_press, w_valid_tran, w_door_open, w_done;
   logic [ITEM_W-1:0]   w_item_code;
   logic                w_load, w_accept, w_cost_valid, w_cost_ok, w_tc, w_to_clear;
   logic [BAL_W-1:0]    w_cost_ext, w_cost_lat_ext;

   assign w_load         = (r_state == ST_IDLE) && bus.LOAD_BAL;
   assign w_accept       = r_req_ready && bus.REQ_VALID && !bus.LOAD_BAL;
   assign w_cost_ext     = {{(BAL_W-COST_W){1'b0}}, bus.COST};
   assign w_cost_lat_ext = {{(BAL_W-COST_W){1'b0}}, r_cost};
   assign w_cost_valid   = (bus.COST != '0);
   assign w_cost_ok      = (w_cost_ext <= r_balance);
   assign w_to_clear     = is_wait(w_state_next) && (w_state_next != r_state);

   vend_timeout_ctr #(
      .LIMIT    (RESP_TIMEOUT)
   ) u_timeout (
      .clk      (CLK),
      .rst      (RESET),
      .i_clear  (w_to_clear),
      .i_enable (is_wait(r_state)),
      .o_tc     (w_tc)
   );

   // State, datapath and registered outputs
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state      <= ST_IDLE;
         r_result     <= RES_OK;
         r_item       <= '0;
         r_cost       <= '0;
         r_balance    <= '0;
         r_hold_cnt   <= '0;
         r_req_ready  <= 1'b0;
         r_card_in    <= 1'b0;
         r_key_press  <= 1'b0;
         r_item_code  <= '0;
         r_valid_tran <= 1'b0;
         r_door_open  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_result     <= w_result_next;
         r_req_ready  <= w_req_ready;
         r_card_in    <= w_card_in;
         r_key_press  <= w_key_press;
         r_item_code  <= w_item_code;
         r_valid_tran <= w_valid_tran;
         r_door_open  <= w_door_open;
         r_done       <= w_done;
         if (w_accept)
            r_item <= bus.REQ_ITEM;
         if ((r_state == ST_WAIT_COST) && (w_state_next == ST_PAY))
            r_cost <= bus.COST;
         if (w_load)
            r_balance <= bus.REQ_BALANCE;
         else if ((r_state == ST_WAIT_VEND) && bus.VEND)
            r_balance <= r_balance - w_cost_lat_ext;
         if (w_state_next != r_state)
            r_hold_cnt <= '0;
         else if ((r_state == ST_GAP) || (r_state == ST_DOOR))
            r_hold_cnt <= r_hold_cnt + 1'b1;
      end
   end

   // Next state; responses take priority over the timeout in the same cycle
   always_comb begin
      w_state_next  = r_state;
      w_result_next = r_result;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_next = ST_INSERT;
         ST_INSERT: w_state_next = ST_KEY1;
         ST_KEY1:   w_state_next = ST_GAP;
         ST_GAP:    if (r_hold_cnt == c_gap_last) w_state_next = ST_KEY2;
         ST_KEY2:   w_state_next = ST_WAIT_COST;
         ST_WAIT_COST: begin
            if (bus.INVALID_SEL) begin
               w_state_next  = ST_EJECT;
               w_result_next = RES_INVALID;
            end else if (w_cost_valid && w_cost_ok) begin
               w_state_next  = ST_PAY;
            end else if (w_cost_valid) begin
               w_state_next  = ST_WAIT_FAIL;
               w_result_next = RES_NO_FUNDS;
            end else if (w_tc) begin
               w_state_next  = ST_EJECT;
               w_result_next = RES_TIMEOUT;
            end
         end
         ST_PAY:    w_state_next = ST_WAIT_VEND;
         ST_WAIT_VEND: begin
            if (bus.VEND) begin
               w_state_next  = ST_DOOR;
            end else if (bus.FAILED_TRAN) begin
               w_state_next  = ST_EJECT;
               w_result_next = RES_FAILED;
            end else if (w_tc) begin
               w_state_next  = ST_EJECT;
               w_result_next = RES_TIMEOUT;
            end
         end
         ST_DOOR: begin
            if (r_hold_cnt == c_door_last) begin
               w_state_next  = ST_EJECT;
               w_result_next = RES_OK;
            end
         end
         ST_WAIT_FAIL: if (bus.FAILED_TRAN || w_tc) w_state_next = ST_EJECT;
         ST_EJECT:  w_state_next = ST_REPORT;
         ST_REPORT: w_state_next = ST_IDLE;
         default:   w_state_next = ST_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they register in step with it
   always_comb begin
      w_req_ready  = 1'b0;
      w_card_in    = 1'b0;
      w_key_press  = 1'b0;
      w_item_code  = '0;
      w_valid_tran = 1'b0;
      w_door_open  = 1'b0;
      w_done       = 1'b0;
      case (w_state_next)
         ST_IDLE:   w_req_ready = 1'b1;
         ST_INSERT: w_card_in   = 1'b1;
         ST_KEY1: begin
            w_card_in   = 1'b1;
            w_key_press = 1'b1;
            w_item_code = r_item[7:4];
         end
         ST_GAP:    w_card_in   = 1'b1;
         ST_KEY2: begin
            w_card_in   = 1'b1;
            w_key_press = 1'b1;
            w_item_code = r_item[3:0];
         end
         ST_WAIT_COST, ST_WAIT_VEND, ST_WAIT_FAIL: begin
            w_card_in   = 1'b1;
            w_item_code = r_item[3:0];
         end
         ST_PAY: begin
            w_card_in    = 1'b1;
            w_item_code  = r_item[3:0];
            w_valid_tran = 1'b1;
         end
         ST_DOOR: begin
            w_card_in   = 1'b1;
            w_item_code = r_item[3:0];
            w_door_open = 1'b1;
         end
         ST_REPORT: w_done = 1'b1;
         default: ;
      endcase
   end

   assign bus.REQ_READY  = r_req_ready;
   assign bus.CARD_IN    = r_card_in;
   assign bus.KEY_PRESS  = r_key_press;
   assign bus.ITEM_CODE  = r_item_code;
   assign bus.VALID_TRAN = r_valid_tran;
   assign bus.DOOR_OPEN  = r_door_open;
   assign bus.DONE       = r_done;
   assign bus.RESULT     = r_result;
   assign bus.BALANCE    = r_balance;

endmodule
`default_nettype wire

// File: tb/tb_vend_customer_agent.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vend_customer_agent : scoreboard bench with a vending machine model|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_vend_customer_agent;
   import vend_pkg::*;

   localparam int BAL_W = 8;

   logic CLK = 1'b0;
   logic RESET = 1'b1;

   vend_customer_agent_if #(.BAL_W(BAL_W)) bus ();

   vend_customer_agent #(
      .BAL_W        (BAL_W),
      .KEY_GAP      (1),
      .RESP_TIMEOUT (8),
      .DOOR_CYCLES  (1)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int exp_res_q[$];
   int exp_bal_q[$];
   int done_count = 0;
   int done_base  = 0;

   // Machine model configuration and observations
   int         mode = 0;
   logic [2:0] m_cost = '0;
   int         k2 = -1;
   int         cyc = 0;
   int         vt_count = 0;
   int         door_count = 0;
   int         drop_at = -1;
   logic       card_prev = 1'b0;
   logic       vt_prev = 1'b0;
   int         keys[$];
   int         key_cyc[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every DONE pulse pops one expected response
   always @(negedge CLK) begin
      if (bus.DONE) begin
         done_count++;
         if (exp_res_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got DONE=1 expected no pulse");
         end else begin
            chk("result", int'(bus.RESULT), exp_res_q.pop_front());
            chk("balance", int'(bus.BALANCE), exp_bal_q.pop_front());
         end
      end
   end

   // Vending machine model, acting one time unit after each rising edge
   initial begin
      bus.VEND = 1'b0;
      bus.INVALID_SEL = 1'b0;
      bus.COST = '0;
      bus.FAILED_TRAN = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         cyc++;
         bus.COST = '0;
         bus.INVALID_SEL = 1'b0;
         bus.VEND = 1'b0;
         bus.FAILED_TRAN = 1'b0;
         if (k2 >= 0) k2++;
         if (bus.KEY_PRESS) begin
            keys.push_back(int'(bus.ITEM_CODE));
            key_cyc.push_back(cyc);
            if (keys.size() == 2) k2 = 0;
         end
         if (bus.VALID_TRAN) vt_count++;
         if (bus.DOOR_OPEN) door_count++;
         if (card_prev && !bus.CARD_IN && (k2 >= 0) && (drop_at < 0)) drop_at = k2;
         card_prev = bus.CARD_IN;
         case (mode)
            1: begin
               if (k2 == 2) bus.COST = m_cost;
               if (vt_prev) bus.VEND = 1'b1;
            end
            2: if (k2 == 2) bus.INVALID_SEL = 1'b1;
            3: begin
               if (k2 == 2) bus.COST = m_cost;
               if (k2 == 7) bus.FAILED_TRAN = 1'b1;
            end
            4: if (k2 == 2) bus.COST = m_cost;
            default: ;
         endcase
         vt_prev = bus.VALID_TRAN;
      end
   end

   task automatic setup(input int md, input logic [2:0] cost, input int res, input int bal,
                        input bit push);
      mode = md;
      m_cost = cost;
      k2 = -1;
      vt_count = 0;
      door_count = 0;
      drop_at = -1;
      keys.delete();
      key_cyc.delete();
      done_base = done_count;
      if (push) begin
         exp_res_q.push_back(res);
         exp_bal_q.push_back(bal);
      end
   endtask

   task automatic handshake(input logic [7:0] item);
      int n;
      n = 0;
      bus.REQ_ITEM = item;
      bus.REQ_VALID = 1'b1;
      while (!bus.REQ_READY && n < 50) begin
         @(posedge CLK); #2;
         n++;
      end
      chk("req_ready", int'(bus.REQ_READY), 1);
      @(posedge CLK); #2;
      bus.REQ_VALID = 1'b0;
   endtask

   task automatic finish_req(input logic [7:0] item, input int exp_vt, input int exp_door,
                             input int exp_drop);
      int n;
      n = 0;
      while ((done_count == done_base) && n < 60) begin
         @(posedge CLK); #2;
         n++;
      end
      repeat (2) begin @(posedge CLK); #2; end
      chk("done_pulses", done_count - done_base, 1);
      chk("key_count", keys.size(), 2);
      if (keys.size() >= 2) begin
         chk("key1_digit", keys[0], int'(item[7:4]));
         chk("key2_digit", keys[1], int'(item[3:0]));
         chk("key_gap", key_cyc[1] - key_cyc[0] - 1, 1);
      end
      chk("valid_tran_cycles", vt_count, exp_vt);
      chk("door_open_cycles", door_count, exp_door);
      chk("card_drop_after_key2", drop_at, exp_drop);
   endtask

   task automatic load_bal(input int v);
      bus.LOAD_BAL = 1'b1;
      bus.REQ_BALANCE = BAL_W'(v);
      @(posedge CLK); #2;
      bus.LOAD_BAL = 1'b0;
      chk("load_bal", int'(bus.BALANCE), v);
   endtask

   initial begin
      int n;
      int d;
      bus.REQ_VALID = 1'b0;
      bus.REQ_ITEM = '0;
      bus.LOAD_BAL = 1'b0;
      bus.REQ_BALANCE = '0;
      repeat (2) @(posedge CLK);
      #2;
      chk("rst_card_in", int'(bus.CARD_IN), 0);
      chk("rst_key_press", int'(bus.KEY_PRESS), 0);
      chk("rst_valid_tran", int'(bus.VALID_TRAN), 0);
      chk("rst_door_open", int'(bus.DOOR_OPEN), 0);
      chk("rst_done", int'(bus.DONE), 0);
      chk("rst_result", int'(bus.RESULT), 0);
      chk("rst_balance", int'(bus.BALANCE), 0);
      RESET = 1'b0;
      @(posedge CLK); #2;
      chk("ready_after_rst", int'(bus.REQ_READY), 1);

      // Successful purchase
      load_bal(10);
      setup(1, 3'd3, RES_OK, 7, 1'b1);
      handshake(8'h13);
      finish_req(8'h13, 1, 1, 6);

      // Invalid selection
      setup(2, 3'd0, RES_INVALID, 7, 1'b1);
      handshake(8'h27);
      finish_req(8'h27, 0, 0, 3);

      // Insufficient funds, machine later reports failure
      load_bal(2);
      setup(3, 3'd4, RES_NO_FUNDS, 2, 1'b1);
      handshake(8'h07);
      finish_req(8'h07, 0, 0, 8);

      // Silent machine
      setup(0, 3'd0, RES_TIMEOUT, 2, 1'b1);
      handshake(8'h35);
      finish_req(8'h35, 0, 0, 9);

      // Reset while waiting for VEND
      setup(4, 3'd2, 0, 0, 1'b0);
      handshake(8'h45);
      n = 0;
      while (vt_count == 0 && n < 40) begin
         @(posedge CLK); #2;
         n++;
      end
      chk("t5_valid_tran", vt_count, 1);
      @(posedge CLK); #3;
      chk("t5_card_before", int'(bus.CARD_IN), 1);
      d = done_count;
      RESET = 1'b1;
      #1;
      chk("t5_card_async", int'(bus.CARD_IN), 0);
      chk("t5_vt_async", int'(bus.VALID_TRAN), 0);
      chk("t5_door_async", int'(bus.DOOR_OPEN), 0);
      chk("t5_bal_async", int'(bus.BALANCE), 0);
      repeat (3) @(posedge CLK);
      #2;
      RESET = 1'b0;
      mode = 0;
      @(posedge CLK); #2;
      chk("t5_ready_after", int'(bus.REQ_READY), 1);
      repeat (8) begin @(posedge CLK); #2; end
      chk("t5_no_done", done_count - d, 0);

      // Balance load and request in the same cycle
      setup(1, 3'd3, RES_OK, 2, 1'b1);
      bus.LOAD_BAL = 1'b1;
      bus.REQ_BALANCE = 8'd5;
      bus.REQ_ITEM = 8'h13;
      bus.REQ_VALID = 1'b1;
      @(posedge CLK); #2;
      chk("t6_bal_loaded", int'(bus.BALANCE), 5);
      chk("t6_not_accepted", int'(bus.CARD_IN), 0);
      bus.LOAD_BAL = 1'b0;
      @(posedge CLK); #2;
      chk("t6_accepted", int'(bus.CARD_IN), 1);
      bus.REQ_VALID = 1'b0;
      finish_req(8'h13, 1, 1, 6);

      chk("scoreboard_empty", exp_res_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
